// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: one miss at a time, critical-word-first AHB-Lite WRAP4 read burst.
// Optional bus-error abort is compiled in with `define ICACHE_REFILL_HRESP_EN.
module icache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_miss_valid,
    output logic                         o_miss_ready,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    output logic [ADDR_W-1:0]            o_haddr,
    output logic [1:0]                   o_htrans,
    output logic [2:0]                   o_hburst,
    output logic [2:0]                   o_hsize,
    output logic                         o_hwrite,
    input  logic [DATA_W-1:0]            i_hrdata,
    input  logic                         i_hready,
    input  logic                         i_hresp,
    output logic                         o_crit_valid,
    output logic [DATA_W-1:0]            o_crit_data,
    output logic                         o_line_valid,
    output logic                         o_line_err,
    output logic [ADDR_W-1:0]            o_line_addr,
    output logic [LINE_WORDS*DATA_W-1:0] o_line_data,
    output logic                         o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ADDR_W-1:2] r_addr;
    logic [2:0]        r_acnt;
    logic [1:0]        r_dcnt;
    logic              r_crit_valid;
    logic [DATA_W-1:0] r_crit_data;
    logic              r_err;

    logic       w_accept;
    logic       w_hresp;
    logic       w_beat;
    logic       w_err_end;
    logic       w_last_beat;
    logic       w_acnt_inc;
    logic       w_on_bus;
    logic [1:0] w_aslot;
    logic [1:0] w_dslot;
    logic       w_unused;

`ifdef ICACHE_REFILL_HRESP_EN
    assign w_hresp = i_hresp;
`else
    assign w_hresp = 1'b0;
`endif

    // Word-offset bits and (in the default build) hresp carry no information here.
    assign w_unused = ^{i_miss_addr[1:0], i_hresp};

    assign w_accept    = (r_state == S_IDLE) && i_miss_valid;
    assign w_beat      = (r_state == S_DATA) && i_hready && !w_hresp;
    assign w_err_end   = (r_state == S_DATA) && i_hready && w_hresp;
    assign w_last_beat = w_beat && (r_dcnt == 2'(LINE_WORDS - 1));
    assign w_on_bus    = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_acnt_inc  = i_hready && ((r_state == S_ADDR) ||
                         ((r_state == S_DATA) && !w_hresp && !r_err &&
                          (r_acnt < 3'(LINE_WORDS))));

    // Slot arithmetic wraps inside the 16-byte line, giving the WRAP4 order.
    assign w_aslot = r_addr[3:2] + r_acnt[1:0];
    assign w_dslot = r_addr[3:2] + r_dcnt;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ADDR;
            S_ADDR:  if (i_hready) w_state_next = S_DATA;
            S_DATA:  if (w_err_end || w_last_beat) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_acnt       <= '0;
            r_dcnt       <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_crit_valid <= w_beat && (r_dcnt == 2'd0);
            if (w_beat && (r_dcnt == 2'd0))
                r_crit_data <= i_hrdata;
            if (w_accept) begin
                r_addr <= i_miss_addr[ADDR_W-1:2];
                r_acnt <= '0;
                r_dcnt <= '0;
                r_err  <= 1'b0;
            end else begin
                if (w_acnt_inc)
                    r_acnt <= r_acnt + 3'd1;
                if (w_beat)
                    r_dcnt <= r_dcnt + 2'd1;
                // First ERROR cycle has hready low; latch it so the next cycle goes IDLE on the bus.
                if ((r_state == S_DATA) && w_hresp)
                    r_err <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [DATA_W-1:0] r_word;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    r_word <= '0;
                else if (w_beat && (w_dslot == 2'(gi)))
                    r_word <= i_hrdata;
            end
            assign o_line_data[gi*DATA_W +: DATA_W] = r_word;
        end
    endgenerate

    always_comb begin
        o_htrans = HTRANS_IDLE;
        case (r_state)
            S_ADDR:  o_htrans = HTRANS_NONSEQ;
            S_DATA:  o_htrans = ((r_acnt < 3'(LINE_WORDS)) && !r_err) ? HTRANS_SEQ : HTRANS_IDLE;
            default: o_htrans = HTRANS_IDLE;
        endcase
    end

    assign o_haddr      = w_on_bus ? {r_addr[ADDR_W-1:4], w_aslot, 2'b00} : '0;
    assign o_hburst     = w_on_bus ? 3'b010 : 3'b000;
    assign o_hsize      = 3'b010;
    assign o_hwrite     = 1'b0;
    assign o_miss_ready = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_crit_valid = r_crit_valid;
    assign o_crit_data  = r_crit_data;
    assign o_line_addr  = {r_addr[ADDR_W-1:4], 4'b0000};
    assign o_line_valid = (r_state == S_DONE) && !r_err;
`ifdef ICACHE_REFILL_HRESP_EN
    assign o_line_err   = (r_state == S_DONE) && r_err;
`else
    assign o_line_err   = 1'b0;
`endif

endmodule
